alu_dec_pipe: RTL and testbench
===============================

Name: alu_dec_pipe

Overview:
Parametrised, registered successor to the combinational ALU opcode decoder. It accepts opcodes with an opaque tag over a valid/ready handshake, decodes each into ALU op, immediate-select and error, and buffers results in a DEPTH-entry FIFO toward the execute stage. It also keeps a sticky error flag and a saturating illegal-opcode counter for debug. It sits between the fetch/issue logic and the ALU in the control path.

Parameters:
OP_W, 5, input opcode width; must be >= 5; bits above [4:0] must be zero for a legal opcode
ALU_OP_W, 4, ALU op width; must be >= 4; decoded value is zero-extended
TAG_W, 8, opaque sideband (e.g. dest reg / PC tag) carried with each entry
DEPTH, 2, output FIFO entries; must be a power of two, >= 2
ERR_CNT_W, 8, illegal-opcode counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  opcode present
in_ready  out  1  block can accept; equals !full
in_op  in  OP_W  opcode
in_tag  in  TAG_W  sideband
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head
out_alu_op  out  ALU_OP_W  decoded ALU op of head entry
out_imm_sel  out  1  immediate select of head entry
out_err  out  1  head entry opcode is illegal
out_tag  out  TAG_W  sideband of head entry
err_sticky  out  1  set when any illegal opcode is accepted
err_count  out  ERR_CNT_W  saturating count of accepted illegal opcodes
clr_err  in  1  synchronous clear of err_sticky and err_count

Behaviour:
- Reset (async, rst_n=0): FIFO empty, out_valid=0, in_ready=1, err_sticky=0, err_count=0. Head data outputs = 0.
- Accept: in_valid & in_ready. Push is {alu_op, imm_sel, err, tag}, decoded combinationally from in_op in the accept cycle.
- Pop: out_valid & out_ready.
- Latency: an entry accepted in cycle N is visible at the outputs (out_valid=1) in cycle N+1 when the FIFO was empty. There is no bypass.
- Decode table (op -> alu_op, imm):
  - ADD 00000 -> 0000,0; ADDI 00001 -> 0000,1
  - SUB 00011 -> 0001,0; SUBI 00100 -> 0001,1
  - AND 00101 -> 0010,0; OR 00110 -> 0011,0; XOR 00111 -> 0100,0; NOT 01000 -> 0101,0
  - JMPI 01001 -> 1101,0; CLR 01011 -> 0110,0; NOP 01100 -> 1111,0
  - CMPE 10010 -> 0111,0; CMPG 10011 -> 1000,0; CMPL 10100 -> 1001,0
  - SHRA 10101 -> 1010,1; SHRL 10110 -> 1011,1; SHL 10111 -> 1100,1
  - Any other value, or any nonzero bit above bit 4 -> 1111,0, err=1.
- Full: in_ready=0. in_valid held without acceptance is legal; in_op and in_tag must then stay stable. A simultaneous push and pop when full is not possible because in_ready is 0.
- Empty: out_valid=0. Head outputs hold their last values and are don't-care for the consumer.
- Simultaneous push and pop when neither full nor empty: occupancy is unchanged and ordering is FIFO.
- Pointers are log2(DEPTH)+1 bits with natural wrap-around. Full and empty are derived from the MSB compare.
- Once out_valid=1, head data must not change until popped.
- Error counter: increments on each accepted entry with err=1 and saturates at all-ones. err_sticky is set on the same condition.
- clr_err with an illegal accept in the same cycle: err_count=1 and err_sticky=1. The new event survives the clear.
- Reset mid-operation discards all entries immediately.

Optional Feature:
ALU_DEC_FLUSH_EN
- Defined: adds input port flush (1 bit). On flush=1 the FIFO empties at the next edge and out_valid=0 the following cycle.
- Any accept in the flush cycle is dropped, and is not counted in err_count or err_sticky.
- in_ready stays 1 in the flush cycle.
- Undefined: no flush port and no flush logic.

Decomposition:
- Package alu_dec_pkg contains:
  - typedef enum opcode_e (5-bit, names above)
  - typedef enum alu_op_e (4-bit)
  - struct dec_entry_t
  - function decode_op() returning alu_op, imm and err
  - localparam ALU_OP_NOP=4'b1111
- Sub-module alu_dec_fifo: generic DEPTH x width synchronous FIFO with valid/ready ports and the optional flush. The top contains the decode, counters and FIFO instance.

Test Plan:
- Reset, then push ADDI (00001, tag 0x5A) with out_ready=1 -> next cycle out_valid=1, alu_op=0000, imm=1, err=0, tag=0x5A.
- Sweep all 32 opcodes, then OP_W=6 with in_op=6'b100000 -> table match; 6'b100000 gives 1111,0,err=1; err_count = (number of illegal codes + 1).
- out_ready=0 with DEPTH=2 and 3 pushes -> in_ready=0 after 2 accepts; third held. Drain -> order preserved, third accepted on the first pop.
- Continuous push/pop streaming 100 random opcodes with random out_ready -> scoreboard matches with no loss or duplication; pointer wrap exercised.
- ERR_CNT_W=2, 5 illegal accepts -> err_count=3 (saturated). clr_err coincident with an illegal accept -> err_count=1, err_sticky=1.
- Assert rst_n low with 2 entries queued -> out_valid=0 and err_count=0 asynchronously. With ALU_DEC_FLUSH_EN, flush plus a concurrent push -> empty and no count.

Source files
------------

// File: rtl/alu_dec_pkg.sv
// alu_dec_pipe shared types: opcode/ALU-op enums, decode entry, decoder.
// decode_op() maps a 5-bit opcode to {alu_op, imm, err}.
package alu_dec_pkg;

  localparam logic [3:0] ALU_OP_NOP = 4'b1111;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_ADDI = 5'b00001,
    OP_SUB  = 5'b00011,
    OP_SUBI = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_XOR  = 5'b00111,
    OP_NOT  = 5'b01000,
    OP_JMPI = 5'b01001,
    OP_CLR  = 5'b01011,
    OP_NOP  = 5'b01100,
    OP_CMPE = 5'b10010,
    OP_CMPG = 5'b10011,
    OP_CMPL = 5'b10100,
    OP_SHRA = 5'b10101,
    OP_SHRL = 5'b10110,
    OP_SHL  = 5'b10111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOT  = 4'h5,
    ALU_CLR  = 4'h6,
    ALU_CMPE = 4'h7,
    ALU_CMPG = 4'h8,
    ALU_CMPL = 4'h9,
    ALU_SHRA = 4'ha,
    ALU_SHRL = 4'hb,
    ALU_SHL  = 4'hc,
    ALU_JMP  = 4'hd,
    ALU_IDLE = 4'hf
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    imm;
    logic    err;
  } dec_entry_t;

  function automatic dec_entry_t decode_op(input logic [4:0] op);
    dec_entry_t d;
    d.alu_op = ALU_IDLE;
    d.imm    = 1'b0;
    d.err    = 1'b0;
    case (op)
      OP_ADD:  d.alu_op = ALU_ADD;
      OP_ADDI: begin d.alu_op = ALU_ADD; d.imm = 1'b1; end
      OP_SUB:  d.alu_op = ALU_SUB;
      OP_SUBI: begin d.alu_op = ALU_SUB; d.imm = 1'b1; end
      OP_AND:  d.alu_op = ALU_AND;
      OP_OR:   d.alu_op = ALU_OR;
      OP_XOR:  d.alu_op = ALU_XOR;
      OP_NOT:  d.alu_op = ALU_NOT;
      OP_JMPI: d.alu_op = ALU_JMP;
      OP_CLR:  d.alu_op = ALU_CLR;
      OP_NOP:  d.alu_op = ALU_IDLE;
      OP_CMPE: d.alu_op = ALU_CMPE;
      OP_CMPG: d.alu_op = ALU_CMPG;
      OP_CMPL: d.alu_op = ALU_CMPL;
      OP_SHRA: begin d.alu_op = ALU_SHRA; d.imm = 1'b1; end
      OP_SHRL: begin d.alu_op = ALU_SHRL; d.imm = 1'b1; end
      OP_SHL:  begin d.alu_op = ALU_SHL; d.imm = 1'b1; end
      default: d.err = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_dec_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO, valid/ready on both sides.
// Optional flush port when ALU_DEC_FLUSH_EN is defined.
module alu_dec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ALU_DEC_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  logic             fl;

`ifdef ALU_DEC_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif

  // Same index, differing lap bit: writer is a full lap ahead.
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);

  assign push_ready = !full || fl;
  assign pop_valid  = !empty;
  assign pop_data   = mem_q[rd_q[AW-1:0]];

  assign do_push = push_valid && push_ready && !fl;
  assign do_pop  = pop_valid && pop_ready;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    if (fl) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/alu_dec_pipe.sv
// Registered ALU opcode decoder: decode on accept, FIFO toward execute,
// sticky error + saturating illegal count. Optional: ALU_DEC_FLUSH_EN.
module alu_dec_pipe
  import alu_dec_pkg::*;
#(
  parameter int OP_W      = 5,
  parameter int ALU_OP_W  = 4,
  parameter int TAG_W     = 8,
  parameter int DEPTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_op,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALU_OP_W-1:0]  out_alu_op,
  output logic                 out_imm_sel,
  output logic                 out_err,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
`ifdef ALU_DEC_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 clr_err
);

  localparam int W = ALU_OP_W + 2 + TAG_W;

  dec_entry_t          dec;
  logic                hi_bad;
  logic                err;
  logic                imm;
  logic [3:0]          alu;
  logic [W-1:0]        push_data;
  logic [W-1:0]        pop_data;
  logic                accept;
  logic                err_evt;
  logic                fl;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                err_sticky_q, err_sticky_d;

`ifdef ALU_DEC_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif

  assign dec    = decode_op(in_op[4:0]);
  assign hi_bad = (in_op >> 5) != '0;
  assign err    = dec.err || hi_bad;
  assign alu    = err ? ALU_OP_NOP : dec.alu_op;
  assign imm    = !err && dec.imm;

  assign push_data = {ALU_OP_W'(alu), imm, err, in_tag};

  alu_dec_fifo #(
    .WIDTH(W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef ALU_DEC_FLUSH_EN
    .flush      (flush),
`endif
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (push_data),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (pop_data)
  );

  assign out_alu_op  = pop_data[W-1 -: ALU_OP_W];
  assign out_imm_sel = pop_data[TAG_W+1];
  assign out_err     = pop_data[TAG_W];
  assign out_tag     = pop_data[TAG_W-1:0];

  // Entries dropped by a flush never reach the counters.
  assign accept  = in_valid && in_ready && !fl;
  assign err_evt = accept && err;

  // A new illegal accept survives a coincident clear.
  always_comb begin
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;
    if (clr_err) begin
      err_count_d  = err_evt ? ERR_CNT_W'(1) : '0;
      err_sticky_d = err_evt;
    end else if (err_evt) begin
      err_sticky_d = 1'b1;
      if (err_count_q != '1) begin
        err_count_d = err_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_alu_dec_pipe.sv
// Self-checking bench for alu_dec_pipe (OP_W=6 to reach upper-bit errors).
// Scoreboard queue filled on accept, drained on pop.
module tb_alu_dec_pipe;

  localparam int OP_W      = 6;
  localparam int ALU_OP_W  = 4;
  localparam int TAG_W     = 8;
  localparam int DEPTH     = 2;
  localparam int ERR_CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [OP_W-1:0]      in_op = '0;
  logic [TAG_W-1:0]     in_tag = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [ALU_OP_W-1:0]  out_alu_op;
  logic                 out_imm_sel;
  logic                 out_err;
  logic [TAG_W-1:0]     out_tag;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 clr_err = 1'b0;
  logic                 flush = 1'b0;

  alu_dec_pipe #(
    .OP_W(OP_W), .ALU_OP_W(ALU_OP_W), .TAG_W(TAG_W),
    .DEPTH(DEPTH), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_imm_sel(out_imm_sel),
    .out_err(out_err), .out_tag(out_tag),
    .err_sticky(err_sticky), .err_count(err_count),
`ifdef ALU_DEC_FLUSH_EN
    .flush(flush),
`endif
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {alu_op[3:0], imm, err}
  function automatic logic [5:0] model_dec(input logic [5:0] op);
    case (op)
      6'd0:    return 6'b000000;
      6'd1:    return 6'b000010;
      6'd3:    return 6'b000100;
      6'd4:    return 6'b000110;
      6'd5:    return 6'b001000;
      6'd6:    return 6'b001100;
      6'd7:    return 6'b010000;
      6'd8:    return 6'b010100;
      6'd9:    return 6'b110100;
      6'd11:   return 6'b011000;
      6'd12:   return 6'b111100;
      6'd18:   return 6'b011100;
      6'd19:   return 6'b100000;
      6'd20:   return 6'b100100;
      6'd21:   return 6'b101010;
      6'd22:   return 6'b101110;
      6'd23:   return 6'b110010;
      default: return 6'b111101;
    endcase
  endfunction

  logic [13:0] sb[$];
  logic [13:0] mon_e;
  logic [5:0]  mon_d;
  logic        mon_evt;
  logic [7:0]  exp_cnt = '0;
  logic        exp_sticky = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("err_count", err_count, exp_cnt);
      check("err_sticky", err_sticky, exp_sticky);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("head", {out_alu_op, out_imm_sel, out_err, out_tag},
                mon_e);
        end
      end
      mon_evt = 1'b0;
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        mon_d = model_dec(in_op);
        sb.push_back({mon_d, in_tag});
        mon_evt = mon_d[0];
      end
      if (clr_err) begin
        exp_cnt    = mon_evt ? 8'd1 : 8'd0;
        exp_sticky = mon_evt;
      end else if (mon_evt) begin
        exp_sticky = 1'b1;
        if (exp_cnt != 8'hff) exp_cnt = exp_cnt + 8'd1;
      end
    end
  end

  task automatic push_op(input logic [5:0] op, input logic [7:0] tag);
    int t = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_tag   = tag;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        break;
      end
      t++;
      if (t > 200) begin
        check("push_timeout", 0, 1);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!out_valid) break;
      t++;
      if (t > 100) begin
        check("drain_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    check("drain_sb_empty", sb.size(), 0);
  endtask

  bit stream_done;

  initial begin
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sticky", err_sticky, 0);
    check("rst_count", err_count, 0);
    check("rst_head", {out_alu_op, out_imm_sel, out_err, out_tag}, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First transaction latency
    out_ready = 1'b1;
    check("pre_valid", out_valid, 0);
    push_op(6'b000001, 8'h5A);
    check("lat_valid", out_valid, 1);
    check("lat_alu", out_alu_op, 4'b0000);
    check("lat_imm", out_imm_sel, 1);
    check("lat_err", out_err, 0);
    check("lat_tag", out_tag, 8'h5A);
    drain();

    // Opcode sweep plus upper-bit illegal
    for (int i = 0; i < 32; i++) push_op(6'(i), 8'(i + 16));
    push_op(6'b100000, 8'hEE);
    drain();
    check("sweep_count", err_count, 16);
    check("sweep_sticky", err_sticky, 1);

    // Backpressure: third push held until a pop frees a slot
    out_ready = 1'b0;
    push_op(6'd3, 8'hA1);
    push_op(6'd21, 8'hA2);
    check("full_valid", out_valid, 1);
    check("full_ready", in_ready, 0);
    fork
      push_op(6'd19, 8'hA3);
      begin
        repeat (3) begin
          @(negedge clk);
          check("full_hold", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Streaming with random backpressure
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          push_op(($urandom_range(0, 9) == 0) ? 6'h20 :
                  6'($urandom_range(0, 31)), 8'($urandom));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Clear, then saturate the counter
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    check("clr_count", err_count, 0);
    check("clr_sticky", err_sticky, 0);
    for (int i = 0; i < 260; i++) push_op(6'd2, 8'(i));
    drain();
    check("sat_count", err_count, 8'hff);

    // Clear coincident with an illegal accept
    in_valid = 1'b1;
    in_op    = 6'd10;
    in_tag   = 8'h77;
    clr_err  = 1'b1;
    @(negedge clk);
    check("clr_acc_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_err  = 1'b0;
    check("clr_acc_count", err_count, 1);
    check("clr_acc_sticky", err_sticky, 1);
    drain();

    // Asynchronous reset with two queued entries
    out_ready = 1'b0;
    push_op(6'd31, 8'hC1);
    push_op(6'd0, 8'hC2);
    check("preq_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_count", err_count, 0);
    check("arst_sticky", err_sticky, 0);
    check("arst_ready", in_ready, 1);
    sb.delete();
    exp_cnt    = '0;
    exp_sticky = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef ALU_DEC_FLUSH_EN
    push_op(6'd5, 8'hD1);
    push_op(6'd6, 8'hD2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = 6'd2;
    in_tag   = 8'hD3;
    @(negedge clk);
    check("flush_ready", in_ready, 1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_count", err_count, 0);
    check("flush_sticky", err_sticky, 0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

endmodule
